// File: rtl/debug_pkg.sv
// debug_pkg: FSM encoding and byte geometry shared across the debug unit
package debug_pkg;
  localparam int BYTE_W = 8;
  localparam int TAM_DATA_DEF = 32;
  localparam int BYTES_PER_WORD = TAM_DATA_DEF / BYTE_W;
  typedef logic [2:0] state_t;
  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_SET_ADDR = 3'd1;
  localparam state_t S_WAIT_RD  = 3'd2;
  localparam state_t S_LATCH    = 3'd3;
  localparam state_t S_SEND     = 3'd4;
  localparam state_t S_WAIT_TX  = 3'd5;
  localparam state_t S_NEXT     = 3'd6;
  localparam state_t S_FINISH   = 3'd7;
  function automatic int bytes_per(input int w);
    return w / BYTE_W;
  endfunction
endpackage

// File: rtl/word_serializer.sv
// word_serializer: holds one memory word and presents it a byte at a time, MSB first
module word_serializer
  import debug_pkg::*;
#(
  parameter int TAM_DATA = 32,
  localparam int BPW = bytes_per(TAM_DATA),
  localparam int BW = BPW > 1 ? $clog2(BPW) : 1
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_load,
  input  logic                i_shift,
  input  logic [TAM_DATA-1:0] i_data,
  input  logic [BW-1:0]       i_idx,
  output logic [BYTE_W-1:0]   o_byte,
  output logic                o_last
);
  logic [TAM_DATA-1:0] shreg;
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) shreg <= '0;
    else if (i_load) shreg <= i_data;
    else if (i_shift) shreg <= shreg << BYTE_W;
  assign o_byte = shreg[TAM_DATA-1 -: BYTE_W];
  assign o_last = i_idx == BW'(BPW - 1);
endmodule

// File: rtl/debug_mem_dumper.sv
// debug_mem_dumper: walks the data-memory debug pointer and streams every word to uart_tx,
// MSB first, over a start/done byte handshake
module debug_mem_dumper
  import debug_pkg::*;
#(
  parameter int TAM_DATA   = 32,
  parameter int NUM_DIREC  = 7,
  parameter int NUM_WORDS  = 128,
  parameter int RD_LATENCY = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [TAM_DATA-1:0]  i_mem_data,
  input  logic                 i_tx_done,
  output logic [NUM_DIREC-1:0] o_mem_pointer,
  output logic [BYTE_W-1:0]    o_tx_data,
  output logic                 o_tx_start,
  output logic                 o_busy,
  output logic                 o_done
);
  localparam int BPW = bytes_per(TAM_DATA);
  localparam int BW = BPW > 1 ? $clog2(BPW) : 1;
  localparam int WW = $clog2(NUM_WORDS) + 1;
  localparam int LW = 2;
  state_t state, state_n;
  logic [WW-1:0] wcnt, wcnt_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic [LW-1:0] lcnt, lcnt_n;
  logic [NUM_DIREC-1:0] ptr_n;
  logic [BYTE_W-1:0] tx_data_n, cur_byte;
  logic tx_start_n, busy_n, done_n, ack, last;
  // a done arriving while o_tx_start is still high belongs to no byte yet
  assign ack = state == S_WAIT_TX && i_tx_done && !o_tx_start;
  word_serializer #(.TAM_DATA(TAM_DATA)) u_ser (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (state == S_LATCH),
    .i_shift (ack),
    .i_data  (i_mem_data),
    .i_idx   (bcnt),
    .o_byte  (cur_byte),
    .o_last  (last)
  );
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      state         <= S_IDLE;
      wcnt          <= '0;
      bcnt          <= '0;
      lcnt          <= '0;
      o_mem_pointer <= '0;
      o_tx_data     <= '0;
      o_tx_start    <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      state         <= state_n;
      wcnt          <= wcnt_n;
      bcnt          <= bcnt_n;
      lcnt          <= lcnt_n;
      o_mem_pointer <= ptr_n;
      o_tx_data     <= tx_data_n;
      o_tx_start    <= tx_start_n;
      o_busy        <= busy_n;
      o_done        <= done_n;
    end
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:     state_n = i_start ? S_SET_ADDR : S_IDLE;
      S_SET_ADDR: state_n = RD_LATENCY == 0 ? S_LATCH : S_WAIT_RD;
      S_WAIT_RD:  state_n = lcnt == LW'(RD_LATENCY == 0 ? 0 : RD_LATENCY - 1) ? S_LATCH : S_WAIT_RD;
      S_LATCH:    state_n = S_SEND;
      S_SEND:     state_n = S_WAIT_TX;
      S_WAIT_TX:  state_n = !ack ? S_WAIT_TX : last ? S_NEXT : S_SEND;
      S_NEXT:     state_n = wcnt == WW'(NUM_WORDS - 1) ? S_FINISH : S_SET_ADDR;
      S_FINISH:   state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
  end
  // next values for every register, so all outputs leave through flops
  always_comb begin
    wcnt_n     = state == S_IDLE && i_start ? '0 :
                 state == S_NEXT && state_n == S_SET_ADDR ? wcnt + 1'b1 : wcnt;
    lcnt_n     = state == S_WAIT_RD ? lcnt + 1'b1 : '0;
    bcnt_n     = state == S_LATCH ? '0 : ack ? bcnt + 1'b1 : bcnt;
    ptr_n      = state == S_SET_ADDR ? NUM_DIREC'(wcnt) : state == S_FINISH ? '0 : o_mem_pointer;
    tx_data_n  = state == S_SEND ? cur_byte : o_tx_data;
    tx_start_n = state == S_SEND;
    busy_n     = state == S_IDLE && i_start ? 1'b1 : state == S_FINISH ? 1'b0 : o_busy;
    done_n     = state == S_FINISH;
  end
endmodule

// File: tb/tb_debug_mem_dumper.sv
// tb_debug_mem_dumper: table-driven dumps on three configurations with a byte scoreboard
module tb_debug_mem_dumper;
  typedef struct {
    int          k;
    int          mlat;
    bit          abuse;
    logic [31:0] base;
    logic [31:0] step;
    int          nb;
  } vec_t;
  typedef struct {
    logic [7:0] b;
    logic [6:0] p;
  } exp_t;
  logic clk = 0;
  logic rst_n = 0;
  logic [2:0] start = '0;
  logic [2:0] start_in, tx_done_m, tx_done_d, tx_done_in, tx_start, busy, done;
  logic [7:0] tx_data [3];
  logic [6:0] ptr [3];
  logic [31:0] md [3];
  logic [31:0] mem [128];
  logic [31:0] r0, d1, d2;
  int cnt [3];
  int mlat = 2;
  bit abuse = 0;
  bit noise = 0;
  int act = 0;
  int n_chk = 0, n_pass = 0, n_tx = 0, n_done = 0;
  exp_t q[$];
  vec_t v [8];
  always #5 clk = ~clk;
  // spurious starts while busy; spurious dones in IDLE, on the tx_start cycle and right after an ack
  for (genvar g = 0; g < 3; g++) begin : g_abuse
    assign start_in[g]   = start[g] | (abuse && busy[g] && noise);
    assign tx_done_in[g] = tx_done_m[g] | (abuse && (tx_done_d[g] | tx_start[g] | !busy[g]));
  end
  always @(posedge clk) begin
    noise <= $urandom_range(0, 3) == 0;
    r0 <= mem[ptr[0]];
    d1 <= mem[ptr[2]];
    d2 <= d1;
    for (int k = 0; k < 3; k++) begin
      tx_done_d[k] <= tx_done_m[k];
      tx_done_m[k] <= cnt[k] == 1;
      cnt[k] <= tx_start[k] ? 5 : cnt[k] > 0 ? cnt[k] - 1 : 0;
    end
  end
  assign md[0] = r0;
  assign md[1] = mem[ptr[1]];
  assign md[2] = mlat == 2 ? d2 : d1;
  debug_mem_dumper u0 (
    .i_clk(clk), .i_reset(rst_n), .i_start(start_in[0]), .i_mem_data(md[0]),
    .i_tx_done(tx_done_in[0]), .o_mem_pointer(ptr[0]), .o_tx_data(tx_data[0]),
    .o_tx_start(tx_start[0]), .o_busy(busy[0]), .o_done(done[0]));
  debug_mem_dumper #(.NUM_WORDS(1), .RD_LATENCY(0)) u1 (
    .i_clk(clk), .i_reset(rst_n), .i_start(start_in[1]), .i_mem_data(md[1]),
    .i_tx_done(tx_done_in[1]), .o_mem_pointer(ptr[1]), .o_tx_data(tx_data[1]),
    .o_tx_start(tx_start[1]), .o_busy(busy[1]), .o_done(done[1]));
  debug_mem_dumper #(.NUM_WORDS(3), .RD_LATENCY(2)) u2 (
    .i_clk(clk), .i_reset(rst_n), .i_start(start_in[2]), .i_mem_data(md[2]),
    .i_tx_done(tx_done_in[2]), .o_mem_pointer(ptr[2]), .o_tx_data(tx_data[2]),
    .o_tx_start(tx_start[2]), .o_busy(busy[2]), .o_done(done[2]));
  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, a, e);
  endtask
  task automatic push_words(input int nw);
    exp_t e;
    for (int w = 0; w < nw; w++)
      for (int b = 3; b >= 0; b--) begin
        e.b = mem[w][b*8 +: 8];
        e.p = 7'(w);
        q.push_back(e);
      end
  endtask
  task automatic pulse_start(input int k);
    @(posedge clk); #1 start[k] = 1'b1;
    @(posedge clk); #1 start[k] = 1'b0;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (tx_start[act]) begin
      n_tx++;
      if (q.size() == 0) chk("queue_nonempty", q.size(), 1);
      else begin
        e = q.pop_front();
        chk("tx_byte", tx_data[act], e.b);
        chk("tx_ptr", ptr[act], e.p);
      end
    end
    if (done[act]) n_done++;
  end
  task automatic run(input vec_t t);
    act = t.k;
    mlat = t.mlat;
    n_tx = 0;
    n_done = 0;
    for (int i = 0; i < 128; i++) mem[i] = t.base + i * t.step;
    push_words(t.nb / 4);
    abuse = t.abuse;
    pulse_start(t.k);
    for (int c = 0; c < 20000 && n_done == 0; c++) begin @(negedge clk); #1; end
    chk("done_count", n_done, 1);
    chk("tx_count", n_tx, t.nb);
    chk("busy_after", busy[t.k], 0);
    chk("ptr_after", ptr[t.k], 0);
    chk("queue_left", q.size(), 0);
    q.delete();
    abuse = 0;
  endtask
  initial begin
    v[0] = '{1, 1, 1'b0, 32'hDEADBEEF, 32'h0, 4};
    v[1] = '{1, 1, 1'b1, 32'hDEADBEEF, 32'h0, 4};
    v[2] = '{1, 1, 1'b0, 32'hFF00A55A, 32'h0, 4};
    v[3] = '{2, 2, 1'b0, 32'h12345678, 32'h11111111, 12};
    v[4] = '{2, 1, 1'b0, 32'hCAFEF00D, 32'h01000001, 12};
    v[5] = '{2, 2, 1'b1, 32'h80000001, 32'h7F7F7F7F, 12};
    v[6] = '{0, 1, 1'b0, 32'h0, 32'h01010101, 512};
    v[7] = '{0, 1, 1'b1, 32'hA5C3E100, 32'h00000103, 512};
    for (int i = 0; i < 128; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_ptr", ptr[k], 0);
      chk("rst_data", tx_data[k], 0);
      chk("rst_start", tx_start[k], 0);
      chk("rst_busy", busy[k], 0);
      chk("rst_done", done[k], 0);
    end
    rst_n = 1;
    act = 0;
    n_tx = 0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h11223344 + i;
    push_words(2);
    pulse_start(0);
    for (int c = 0; c < 2000 && n_tx < 6; c++) begin @(negedge clk); #1; end
    chk("pre_rst_tx", n_tx, 6);
    chk("pre_rst_ptr", ptr[0], 1);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_ptr", ptr[0], 0);
    chk("mid_rst_data", tx_data[0], 0);
    chk("mid_rst_start", tx_start[0], 0);
    chk("mid_rst_busy", busy[0], 0);
    chk("mid_rst_done", done[0], 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    n_tx = 0;
    repeat (40) @(negedge clk);
    chk("no_tx_after_rst", n_tx, 0);
    chk("idle_after_rst", busy[0], 0);
    for (int i = 0; i < 8; i++) run(v[i]);
    n_tx = 0;
    n_done = 0;
    repeat (30) @(negedge clk);
    chk("quiet_tx", n_tx, 0);
    chk("quiet_done", n_done, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
